// File: rtl/axis_playback_trigger_gen_pkg.sv
// Shared definitions for axis_playback_trigger_gen: state encodings, widths
// and the saturating-increment helper used by its counters.
package axis_playback_trigger_gen_pkg;

    localparam int STATE_WIDTH = 2;
    localparam int COUNT_WIDTH = 32;
    localparam int C_STATES    = 4;

    localparam logic [STATE_WIDTH-1:0] S_IDLE    = 2'd0;
    localparam logic [STATE_WIDTH-1:0] S_ARMED   = 2'd1;
    localparam logic [STATE_WIDTH-1:0] S_PLAYING = 2'd2;
    localparam logic [STATE_WIDTH-1:0] S_DRAIN   = 2'd3;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
        if (value == {COUNT_WIDTH{1'b1}}) begin
            sat_inc = value;
        end else begin
            sat_inc = value + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/axis_playback_trigger_gen.sv
// Plays tlast-framed MM2S packets out to an unframed DAC stream on a masked trigger.
// Optional macro UNDERRUN_COUNTER_EN adds a saturating underrun_count output.
module axis_playback_trigger_gen
    import axis_playback_trigger_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TRIG_WIDTH = 32
) (
    input  logic                   stream_clk,
    input  logic                   stream_reset,
    input  logic [TRIG_WIDTH-1:0]  trigger,
    input  logic [TRIG_WIDTH-1:0]  trigger_enable,
    input  logic [31:0]            trigger_out_beat,
    input  logic                   start,
    input  logic                   stop,
    output logic                   idle,
    output logic [TRIG_WIDTH-1:0]  trigger_detected,
    output logic [31:0]            packet_beats,
    output logic                   underrun,
    output logic                   trigger_out,
    input  logic [DATA_WIDTH-1:0]  s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic                   s_tlast,
    output logic [DATA_WIDTH-1:0]  m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [1:0]             dbg_state
`ifdef UNDERRUN_COUNTER_EN
    ,
    output logic [31:0]            underrun_count
`endif
);

    logic [STATE_WIDTH-1:0] state;
    logic [STATE_WIDTH-1:0] next_state;
    logic [COUNT_WIDTH-1:0] beat_count;
    logic                   pulsed;
    logic                   trig_hit;
    logic                   play_beat;
    logic                   starved;

    assign trig_hit  = (|(trigger & trigger_enable)) | (trigger_enable == {TRIG_WIDTH{1'b0}});
    assign play_beat = s_tvalid & m_tready;
    assign starved   = m_tready & ~s_tvalid;
    assign idle      = (state == S_IDLE);
    assign dbg_state = state;

    // Next-state selection and the per-state stream handshake muxing.
    always_comb begin
        next_state = state;
        s_tready   = 1'b0;
        m_tvalid   = 1'b0;
        m_tdata    = {DATA_WIDTH{1'b0}};
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_ARMED;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_ARMED: begin
                if (stop) begin
                    next_state = S_IDLE;
                end else if (trig_hit) begin
                    next_state = S_PLAYING;
                end else begin
                    next_state = S_ARMED;
                end
            end
            S_PLAYING: begin
                m_tdata  = s_tdata;
                m_tvalid = s_tvalid;
                s_tready = m_tready;
                // A completing tlast beat wins over a concurrent stop.
                if (play_beat && s_tlast) begin
                    next_state = S_IDLE;
                end else if (stop) begin
                    next_state = S_DRAIN;
                end else begin
                    next_state = S_PLAYING;
                end
            end
            S_DRAIN: begin
                s_tready = 1'b1;
                if (s_tvalid && s_tlast) begin
                    next_state = S_IDLE;
                end else begin
                    next_state = S_DRAIN;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State, beat counter, status registers and the trigger_out pulse.
    always_ff @(posedge stream_clk or posedge stream_reset) begin
        if (stream_reset) begin
            state            <= S_IDLE;
            beat_count       <= {COUNT_WIDTH{1'b0}};
            pulsed           <= 1'b0;
            trigger_detected <= {TRIG_WIDTH{1'b0}};
            packet_beats     <= 32'd0;
            underrun         <= 1'b0;
            trigger_out      <= 1'b0;
        end else begin
            state       <= next_state;
            trigger_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        beat_count <= {COUNT_WIDTH{1'b0}};
                        pulsed     <= 1'b0;
                        underrun   <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (!stop && trig_hit) begin
                        trigger_detected <= trigger & trigger_enable;
                    end
                end
                S_PLAYING: begin
                    if (starved) begin
                        underrun <= 1'b1;
                    end
                    if (play_beat) begin
                        beat_count <= sat_inc(beat_count);
                        // pulsed guards against a repeat once the counter saturates
                        if (!pulsed && (beat_count == trigger_out_beat)) begin
                            trigger_out <= 1'b1;
                            pulsed      <= 1'b1;
                        end
                        if (s_tlast) begin
                            packet_beats <= sat_inc(beat_count);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef UNDERRUN_COUNTER_EN
    // Saturating count of starved cycles during playback.
    always_ff @(posedge stream_clk or posedge stream_reset) begin
        if (stream_reset) begin
            underrun_count <= 32'd0;
        end else if ((state == S_IDLE) && start) begin
            underrun_count <= 32'd0;
        end else if ((state == S_PLAYING) && starved) begin
            underrun_count <= sat_inc(underrun_count);
        end
    end
`endif

endmodule

// File: tb/tb_axis_playback_trigger_gen.sv
// Directed self-checking bench for axis_playback_trigger_gen.
module tb_axis_playback_trigger_gen;

    logic        stream_clk = 1'b0;
    logic        stream_reset = 1'b1;
    logic [31:0] trigger = 32'd0;
    logic [31:0] trigger_enable = 32'd0;
    logic [31:0] trigger_out_beat = 32'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        idle;
    logic [31:0] trigger_detected;
    logic [31:0] packet_beats;
    logic        underrun;
    logic        trigger_out;
    logic [31:0] s_tdata = 32'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [1:0]  dbg_state;
`ifdef UNDERRUN_COUNTER_EN
    logic [31:0] underrun_count;
`endif

    int n_checks = 0;
    int n_fail = 0;

    axis_playback_trigger_gen #(.DATA_WIDTH(32), .TRIG_WIDTH(32)) dut (
        .stream_clk(stream_clk),
        .stream_reset(stream_reset),
        .trigger(trigger),
        .trigger_enable(trigger_enable),
        .trigger_out_beat(trigger_out_beat),
        .start(start),
        .stop(stop),
        .idle(idle),
        .trigger_detected(trigger_detected),
        .packet_beats(packet_beats),
        .underrun(underrun),
        .trigger_out(trigger_out),
        .s_tdata(s_tdata),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .s_tlast(s_tlast),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .dbg_state(dbg_state)
`ifdef UNDERRUN_COUNTER_EN
        ,
        .underrun_count(underrun_count)
`endif
    );

    always #5 stream_clk = ~stream_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge stream_clk);
        #1;
    endtask

    // One accepted beat in S_PLAYING with m_tready high.
    task automatic beat(input logic [31:0] d, input logic last, input logic exp_pulse, input string tag);
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = last;
        #1;
        check({tag, "_mdata"}, m_tdata, d);
        check({tag, "_mvalid"}, m_tvalid, 1'b1);
        @(posedge stream_clk);
        #1;
        check({tag, "_tout"}, trigger_out, exp_pulse);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic arm_and_play();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    initial begin
        int idx;
        logic done;

        // Reset values
        step();
        check("rst_idle", idle, 1'b1);
        check("rst_state", dbg_state, 2'd0);
        check("rst_pbeats", packet_beats, 32'd0);
        check("rst_tout", trigger_out, 1'b0);
        check("rst_sready", s_tready, 1'b0);
        stream_reset = 1'b0;
        step();

        // Immediate start, 8-beat packet, pulse after beat 3
        trigger_enable   = 32'd0;
        trigger_out_beat = 32'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        check("imm_armed", dbg_state, 2'd1);
        check("imm_armed_sready", s_tready, 1'b0);
        step();
        check("imm_playing", dbg_state, 2'd2);
        for (int i = 0; i < 8; i++) begin
            beat(32'hA000_0000 + i, (i == 7), (i == 3), $sformatf("imm_b%0d", i));
        end
        check("imm_pbeats", packet_beats, 32'd8);
        check("imm_idle", idle, 1'b1);
        check("imm_urun", underrun, 1'b0);
        check("imm_tdet", trigger_detected, 32'd0);
        check("imm_idle_mvalid", m_tvalid, 1'b0);

        // Masked trigger: wait on bit 2 while bit 0 toggles in
        trigger_enable   = 32'h4;
        trigger          = 32'h1;
        trigger_out_beat = 32'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("mask_wait%0d", i), {dbg_state, s_tready}, {2'd1, 1'b0});
            step();
        end
        trigger = 32'h5;
        #1;
        check("mask_pre_sready", s_tready, 1'b0);
        step();
        trigger = 32'h0;
        check("mask_playing", dbg_state, 2'd2);
        check("mask_sready", s_tready, 1'b1);
        check("mask_tdet", trigger_detected, 32'h4);
        beat(32'h1234_5678, 1'b0, 1'b1, "mask_b0");
        beat(32'h9ABC_DEF0, 1'b1, 1'b0, "mask_b1");
        check("mask_pbeats", packet_beats, 32'd2);

        // Underrun: 3 starved cycles mid-packet
        trigger_enable   = 32'd0;
        trigger_out_beat = 32'd100;
        arm_and_play();
        for (int i = 0; i < 3; i++) begin
            beat(32'h5500_0000 + i, 1'b0, 1'b0, $sformatf("ur_b%0d", i));
        end
        check("ur_before", underrun, 1'b0);
        step();
        step();
        step();
        check("ur_set", underrun, 1'b1);
        beat(32'h5500_0003, 1'b0, 1'b0, "ur_b3");
        beat(32'h5500_0004, 1'b1, 1'b0, "ur_b4");
        check("ur_sticky", underrun, 1'b1);
        check("ur_idle", idle, 1'b1);
        check("ur_pbeats", packet_beats, 32'd5);
`ifdef UNDERRUN_COUNTER_EN
        check("ur_count", underrun_count, 32'd3);
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        check("ur_cleared", underrun, 1'b0);
        check("ur_rearmed", dbg_state, 2'd1);
`ifdef UNDERRUN_COUNTER_EN
        check("ur_count_clr", underrun_count, 32'd0);
`endif
        // stop beats the always-true trigger while armed
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("armed_stop_idle", dbg_state, 2'd0);

        // Stop at beat 4 of 16 then drain the rest
        arm_and_play();
        for (int i = 0; i < 4; i++) begin
            beat(32'h7700_0000 + i, 1'b0, 1'b0, $sformatf("stop_b%0d", i));
        end
        s_tdata  = 32'h7700_0004;
        s_tvalid = 1'b1;
        stop     = 1'b1;
        step();
        stop = 1'b0;
        check("drain_state", dbg_state, 2'd3);
        check("drain_mvalid", m_tvalid, 1'b0);
        check("drain_sready", s_tready, 1'b1);
        for (int k = 5; k < 16; k++) begin
            s_tdata = 32'h7700_0000 + k;
            s_tlast = (k == 15);
            #1;
            check($sformatf("drain_mv%0d", k), m_tvalid, 1'b0);
            step();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("drain_idle", idle, 1'b1);
        check("drain_pbeats", packet_beats, 32'd5);

        // Backpressure with out-of-range trigger_out_beat
        trigger_out_beat = 32'd100;
        arm_and_play();
        idx  = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            m_tready = c[0];
            s_tvalid = 1'b1;
            s_tdata  = 32'hBB00_0000 + idx;
            s_tlast  = (idx == 9);
            #1;
            check($sformatf("bp_sready%0d", c), s_tready, m_tready);
            step();
            check($sformatf("bp_tout%0d", c), trigger_out, 1'b0);
            if (m_tready) begin
                if (idx == 9) begin
                    done = 1'b1;
                end
                idx++;
            end
        end
        m_tready = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("bp_done", done, 1'b1);
        check("bp_pbeats", packet_beats, 32'd10);
        check("bp_urun", underrun, 1'b0);
        check("bp_idle", idle, 1'b1);

        // One-beat packet with pulse on beat 0
        trigger_out_beat = 32'd0;
        arm_and_play();
        beat(32'hC0DE_0001, 1'b1, 1'b1, "one_b0");
        check("one_pbeats", packet_beats, 32'd1);
        check("one_idle", idle, 1'b1);

        // Asynchronous reset in the middle of beat 5
        trigger_enable   = 32'h2;
        trigger          = 32'h2;
        trigger_out_beat = 32'd2;
        arm_and_play();
        check("ar_tdet_pre", trigger_detected, 32'h2);
        for (int i = 0; i < 5; i++) begin
            beat(32'hD000_0000 + i, 1'b0, (i == 2), $sformatf("ar_b%0d", i));
        end
        s_tdata  = 32'hD000_0005;
        s_tvalid = 1'b1;
        #1;
        check("ar_mvalid_pre", m_tvalid, 1'b1);
        #1;
        stream_reset = 1'b1;
        #1;
        check("ar_state", dbg_state, 2'd0);
        check("ar_idle", idle, 1'b1);
        check("ar_mvalid", m_tvalid, 1'b0);
        check("ar_mdata", m_tdata, 32'd0);
        check("ar_sready", s_tready, 1'b0);
        check("ar_pbeats", packet_beats, 32'd0);
        check("ar_tdet", trigger_detected, 32'd0);
        check("ar_urun", underrun, 1'b0);
        check("ar_tout", trigger_out, 1'b0);
        s_tvalid = 1'b0;
        trigger  = 32'd0;
        step();
        @(negedge stream_clk);
        stream_reset = 1'b0;
        step();
        check("ar_after_idle", idle, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_playback_trigger_gen.md
Name: axis_playback_trigger_gen

Overview:
- Transmit-side counterpart to the capture-path trigger/tlast injector.
- Consumes tlast-framed AXI4-Stream packets from the MM2S DMA and plays each packet out to the DAC/output stream, starting on a masked trigger condition.
- Emits a one-cycle trigger pulse at a programmed beat offset and reports the played packet length, so software and external logic can align on the waveform.
- Sits between DMA MM2S and the DAC stream interface, in the DAC stream clock domain, controlled by software registers.

Parameters:
- DATA_WIDTH, 32, width of s_tdata/m_tdata.
- TRIG_WIDTH, 32, width of the trigger input and enable mask.

Ports:
- stream_clk  input  1  stream clock; all logic is synchronous to it.
- stream_reset  input  1  asynchronous, active-high reset.
- trigger  input  TRIG_WIDTH  start-condition inputs.
- trigger_enable  input  TRIG_WIDTH  mask for trigger; all-zero means start immediately.
- trigger_out_beat  input  32  beat index, from 0 at packet start, on which trigger_out pulses.
- start  input  1  arms the block; honoured only in S_IDLE.
- stop  input  1  aborts playback; honoured in S_ARMED and S_PLAYING.
- idle  output  1  high in S_IDLE.
- trigger_detected  output  TRIG_WIDTH  masked trigger value that started the last playback.
- packet_beats  output  32  beat count of the last completed packet.
- underrun  output  1  sticky flag: s_tvalid was low while m_tready was high in S_PLAYING.
- trigger_out  output  1  registered one-cycle pulse.
- s_tdata  input  DATA_WIDTH  slave data.
- s_tvalid  input  1  slave valid.
- s_tready  output  1  slave ready.
- s_tlast  input  1  slave last.
- m_tdata  output  DATA_WIDTH  master data.
- m_tvalid  output  1  master valid.
- m_tready  input  1  master ready.
- dbg_state  output  2  current state encoding.

Behaviour:
- States and encodings: S_IDLE=0, S_ARMED=1, S_PLAYING=2, S_DRAIN=3.
- Reset values: state=S_IDLE, idle=1, trigger_detected=0, packet_beats=0, underrun=0, trigger_out=0, beat counter=0.
- S_IDLE:
  - s_tready=0, m_tvalid=0, m_tdata=0.
  - start -> S_ARMED; clears underrun and the beat counter.
- S_ARMED:
  - s_tready=0 (DMA is held off).
  - Trigger condition is |(trigger & trigger_enable), or trigger_enable==0.
  - On trigger condition -> S_PLAYING; trigger_detected <= trigger & trigger_enable in the same cycle.
  - stop -> S_IDLE. stop takes priority over a simultaneous trigger.
- S_PLAYING:
  - Zero-latency passthrough: m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready.
  - A beat is s_tvalid & m_tready. Each beat increments the 32-bit beat counter, which saturates at 0xFFFFFFFF.
  - trigger_out is asserted the cycle after the beat whose pre-increment count equals trigger_out_beat. It pulses at most once per packet.
  - underrun is set in any cycle where m_tready=1 and s_tvalid=0.
  - On a beat with s_tlast=1 -> S_IDLE; packet_beats <= count+1.
  - stop (without a concurrent tlast beat) -> S_DRAIN; packet_beats is not updated.
  - A tlast beat with simultaneous stop completes normally -> S_IDLE.
- S_DRAIN:
  - s_tready=1, m_tvalid=0; slave beats are discarded.
  - A beat with s_tlast=1 -> S_IDLE.
- Boundaries:
  - trigger_out_beat >= packet length: no pulse.
  - One-beat packet (tlast on beat 0) with trigger_out_beat=0: pulse fires, packet_beats=1.
  - start outside S_IDLE is ignored. stop in S_IDLE or S_DRAIN is ignored.
  - Reset asserted mid-packet returns all state to reset values immediately. Upstream must be flushed by software.
- m_tlast is not provided: the DAC stream is unframed.

Optional Feature:
- Macro: UNDERRUN_COUNTER_EN.
- Defined: adds output port underrun_count (32 bits).
  - Increments, saturating, on every underrun cycle in S_PLAYING.
  - Cleared on start in S_IDLE and on reset.
- Undefined: the port is absent; only the sticky underrun flag exists.

Decomposition:
- Shared package holds:
  - state localparams S_IDLE..S_DRAIN and C_STATES=4;
  - STATE_WIDTH=2;
  - COUNT_WIDTH=32.
- Sub-module: reuse the existing counter (beat counter, sync reset on start) and register (trigger_detected, packet_beats, trigger_out, state) primitives.
- No new sub-module is needed.

Test Plan:
- Immediate start: trigger_enable=0, start, 8-beat packet with tlast on beat 7, trigger_out_beat=3 -> m_tdata matches input, trigger_out high the cycle after beat 3, packet_beats=8, idle=1.
- Masked trigger: trigger_enable=0x4, trigger=0x1 for 20 cycles, then 0x5 -> s_tready stays 0 until 0x5, trigger_detected=0x4, playback starts the next cycle.
- Underrun: deassert s_tvalid for 3 cycles mid-packet with m_tready=1 -> underrun=1 persists after the packet; next start clears it; with UNDERRUN_COUNTER_EN, underrun_count=3.
- Stop mid-packet: stop at beat 4 of 16 -> S_DRAIN, m_tvalid=0, remaining 11 beats consumed, S_IDLE after tlast, packet_beats unchanged.
- Backpressure and boundary: m_tready toggling 50%, trigger_out_beat=100 on a 10-beat packet -> no trigger_out, packet_beats=10, no underrun.
- Async reset asserted at beat 5 -> all outputs return to reset values without a clock edge; state=S_IDLE.
